// File: rtl/adam_pause_sequencer.sv
// adam_pause_sequencer
// Fans a single upstream pause handshake out to NO_TARGETS downstream pause
// handshakes. Resume releases targets one at a time in ascending index order,
// pause stops them one at a time in descending order, and upstream only sees
// its acknowledge once the whole group has settled. Dependent peripherals
// therefore start after, and stop before, the resources they rely on.
module adam_pause_sequencer #(
    parameter int NO_TARGETS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_req,
    output logic                  up_ack,
    input  logic [NO_TARGETS-1:0] en,
    output logic [NO_TARGETS-1:0] dn_req,
    input  logic [NO_TARGETS-1:0] dn_ack,
    output logic                  busy
);

    localparam int               IDX_W    = (NO_TARGETS > 1) ? $clog2(NO_TARGETS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_TARGETS - 1);

    typedef enum logic [1:0] {
        PAUSED,
        RESUMING,
        RUNNING,
        PAUSING
    } state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        index_q;
    logic                    entered_q;
    logic                    stepEn_q;
    logic                    upAck_q;
    logic                    busy_q;
    logic [NO_TARGETS-1:0]   dnReq_q;

    logic                    sequencing;
    logic                    reqLevel;
    logic                    stepDone;
    logic                    lastStep;
    logic                    doEntry;
    logic [IDX_W-1:0]        entryIdx_d;

    // Step bookkeeping: a step finishes when its target's ack matches the
    // request we drive (or at once if the target was skipped), and finishing
    // a non-final step immediately enters the neighbouring one on the same
    // edge, so the next dn_req toggles without a bubble cycle.
    always_comb begin
        sequencing = (state_q == RESUMING) || (state_q == PAUSING);
        reqLevel   = (state_q == PAUSING);
        stepDone   = entered_q && (!stepEn_q || (dn_ack[index_q] == dnReq_q[index_q]));
        lastStep   = (state_q == RESUMING) ? (index_q == LAST_IDX) : (index_q == '0);
        doEntry    = sequencing && (!entered_q || (stepDone && !lastStep));
        entryIdx_d = index_q;
        if (entered_q) begin
            if (state_q == RESUMING) begin
                entryIdx_d = index_q + IDX_W'(1);
            end else begin
                entryIdx_d = index_q - IDX_W'(1);
            end
        end
    end

    // Sequencer FSM: the group sits paused out of reset; en is captured once
    // at the edge entering each step so later changes cannot disturb it, and
    // up_req is only looked at again once the group has settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= PAUSED;
            index_q   <= '0;
            entered_q <= 1'b0;
            stepEn_q  <= 1'b0;
            upAck_q   <= 1'b1;
            busy_q    <= 1'b0;
            dnReq_q   <= '1;
        end else begin
            case (state_q)
                PAUSED: begin
                    if (!up_req) begin
                        state_q   <= RESUMING;
                        index_q   <= '0;
                        entered_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (up_req) begin
                        state_q   <= PAUSING;
                        index_q   <= LAST_IDX;
                        entered_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                RESUMING, PAUSING: begin
                    if (doEntry) begin
                        index_q   <= entryIdx_d;
                        entered_q <= 1'b1;
                        stepEn_q  <= en[entryIdx_d];
                        if (en[entryIdx_d]) begin
                            dnReq_q[entryIdx_d] <= reqLevel;
                        end
                    end else if (stepDone && lastStep) begin
                        state_q   <= (state_q == RESUMING) ? RUNNING : PAUSED;
                        upAck_q   <= reqLevel;
                        busy_q    <= 1'b0;
                        entered_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= PAUSED;
                end
            endcase
        end
    end

    assign up_ack = upAck_q;
    assign dn_req = dnReq_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_adam_pause_sequencer.sv
// tb_adam_pause_sequencer
// Directed bench for the four-target pause sequencer. Each downstream target
// is a registered follower that acks one cycle after its request changes,
// unless its bit in stallMask freezes the ack. Edge n below is the n-th
// rising clock edge after up_req changes, edge 0 being the one that samples it.
module tb_adam_pause_sequencer;

    logic       clock;
    logic       reset;
    logic       upReq;
    logic       upAck;
    logic [3:0] en;
    logic [3:0] dnReq;
    logic [3:0] dnAck;
    logic       busy;
    logic [3:0] stallMask;

    int compareCount;
    int mismatchCount;

    adam_pause_sequencer #(
        .NO_TARGETS(4)
    ) dut (
        .clk    (clock),
        .rst    (reset),
        .up_req (upReq),
        .up_ack (upAck),
        .en     (en),
        .dn_req (dnReq),
        .dn_ack (dnAck),
        .busy   (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Downstream targets: paused in reset, follow their request one cycle
    // later, and hold their ack while stalled.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            dnAck <= 4'b1111;
        end else begin
            dnAck <= (dnAck & stallMask) | (dnReq & ~stallMask);
        end
    end

    // One clock edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset asserted mid-cycle must force the paused state with no clock edge.
    task automatic test_reset();
        upReq     = 1'b1;
        en        = 4'b1111;
        stallMask = 4'b0000;
        reset     = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        compareCount++;
        if (dnReq !== 4'b1111) begin
            mismatchCount++;
            $display("[TB] FAIL reset_async dn_req: got %b expected %b", dnReq, 4'b1111);
        end
        compareCount++;
        if (upAck !== 1'b1) begin
            mismatchCount++;
            $display("[TB] FAIL reset_async up_ack: got %b expected 1", upAck);
        end
        compareCount++;
        if (busy !== 1'b0) begin
            mismatchCount++;
            $display("[TB] FAIL reset_async busy: got %b expected 0", busy);
        end
        @(posedge clock);
        @(posedge clock);
        #3;
        reset = 1'b0;
        tick();
        compareCount++;
        if ({dnReq, upAck, busy} !== 6'b1111_1_0) begin
            mismatchCount++;
            $display("[TB] FAIL reset_release {dn_req,up_ack,busy}: got %b expected %b", {dnReq, upAck, busy}, 6'b1111_1_0);
        end
    endtask

    // Resume with every target enabled: dn_req bits fall at edges 1,3,5,7,
    // up_ack falls at edge 9, one dn_req bit changing at most per edge.
    task automatic test_resume_all();
        int         fallEdge[4];
        logic [3:0] expDn;
        logic [3:0] prevDn;
        logic       expLow;
        fallEdge = '{1, 3, 5, 7};
        en       = 4'b1111;
        prevDn   = dnReq;
        upReq    = 1'b0;
        for (int n = 0; n <= 10; n++) begin
            tick();
            for (int i = 0; i < 4; i++) expDn[i] = (n >= fallEdge[i]) ? 1'b0 : 1'b1;
            expLow = (n < 9);
            compareCount++;
            if (dnReq !== expDn) begin
                mismatchCount++;
                $display("[TB] FAIL resume_all dn_req edge %0d: got %b expected %b", n, dnReq, expDn);
            end
            compareCount++;
            if (upAck !== expLow) begin
                mismatchCount++;
                $display("[TB] FAIL resume_all up_ack edge %0d: got %b expected %b", n, upAck, expLow);
            end
            compareCount++;
            if (busy !== expLow) begin
                mismatchCount++;
                $display("[TB] FAIL resume_all busy edge %0d: got %b expected %b", n, busy, expLow);
            end
            compareCount++;
            if ($countones(dnReq ^ prevDn) > 1) begin
                mismatchCount++;
                $display("[TB] FAIL resume_all single_toggle edge %0d: got %b after %b", n, dnReq, prevDn);
            end
            prevDn = dnReq;
        end
    endtask

    // Pause with every target enabled: dn_req[3..0] rise at edges 1,3,5,7,
    // up_ack rises at edge 9.
    task automatic test_pause_all();
        int         riseEdge[4];
        logic [3:0] expDn;
        logic       expAck;
        riseEdge = '{7, 5, 3, 1};
        upReq    = 1'b1;
        for (int n = 0; n <= 10; n++) begin
            tick();
            for (int i = 0; i < 4; i++) expDn[i] = (n >= riseEdge[i]) ? 1'b1 : 1'b0;
            expAck = (n >= 9);
            compareCount++;
            if (dnReq !== expDn) begin
                mismatchCount++;
                $display("[TB] FAIL pause_all dn_req edge %0d: got %b expected %b", n, dnReq, expDn);
            end
            compareCount++;
            if (upAck !== expAck) begin
                mismatchCount++;
                $display("[TB] FAIL pause_all up_ack edge %0d: got %b expected %b", n, upAck, expAck);
            end
            compareCount++;
            if (busy !== !expAck) begin
                mismatchCount++;
                $display("[TB] FAIL pause_all busy edge %0d: got %b expected %b", n, busy, !expAck);
            end
        end
    endtask

    // Targets 0 and 2 disabled: they keep dn_req high, and each skipped step
    // costs one cycle (resume ack at edge 7, pause ack at edge 7).
    task automatic test_skip();
        int         fallEdge[4];
        int         riseEdge[4];
        logic [3:0] expDn;
        logic [3:0] prevDn;
        logic       expAck;
        fallEdge = '{1000, 2, 1000, 5};
        riseEdge = '{0, 4, 0, 1};
        en       = 4'b1010;
        prevDn   = dnReq;
        upReq    = 1'b0;
        for (int n = 0; n <= 8; n++) begin
            tick();
            for (int i = 0; i < 4; i++) expDn[i] = (n >= fallEdge[i]) ? 1'b0 : 1'b1;
            expAck = (n < 7);
            compareCount++;
            if (dnReq !== expDn) begin
                mismatchCount++;
                $display("[TB] FAIL skip_resume dn_req edge %0d: got %b expected %b", n, dnReq, expDn);
            end
            compareCount++;
            if (upAck !== expAck) begin
                mismatchCount++;
                $display("[TB] FAIL skip_resume up_ack edge %0d: got %b expected %b", n, upAck, expAck);
            end
            compareCount++;
            if ($countones(dnReq ^ prevDn) > 1) begin
                mismatchCount++;
                $display("[TB] FAIL skip_resume single_toggle edge %0d: got %b after %b", n, dnReq, prevDn);
            end
            prevDn = dnReq;
        end
        upReq = 1'b1;
        for (int n = 0; n <= 8; n++) begin
            tick();
            for (int i = 0; i < 4; i++) expDn[i] = (n >= riseEdge[i]) ? 1'b1 : 1'b0;
            expAck = (n >= 7);
            compareCount++;
            if (dnReq !== expDn) begin
                mismatchCount++;
                $display("[TB] FAIL skip_pause dn_req edge %0d: got %b expected %b", n, dnReq, expDn);
            end
            compareCount++;
            if (upAck !== expAck) begin
                mismatchCount++;
                $display("[TB] FAIL skip_pause up_ack edge %0d: got %b expected %b", n, upAck, expAck);
            end
        end
    endtask

    // up_req flips back to pause while resuming index 1: the resume still
    // completes at edge 9, RUNNING lasts one cycle, pausing starts at edge 10
    // and finishes with up_ack high at edge 19.
    task automatic test_reversal();
        en    = 4'b1111;
        upReq = 1'b0;
        for (int n = 0; n <= 20; n++) begin
            tick();
            if (n == 3) upReq = 1'b1;
            if (n == 7) begin
                compareCount++;
                if (dnReq !== 4'b0000) begin
                    mismatchCount++;
                    $display("[TB] FAIL reversal resume_finishes dn_req: got %b expected 0000", dnReq);
                end
            end
            if (n == 9) begin
                compareCount++;
                if ({upAck, busy} !== 2'b00) begin
                    mismatchCount++;
                    $display("[TB] FAIL reversal settled {up_ack,busy}: got %b expected 00", {upAck, busy});
                end
            end
            if (n == 10) begin
                compareCount++;
                if ({upAck, busy, dnReq} !== 6'b0_1_0000) begin
                    mismatchCount++;
                    $display("[TB] FAIL reversal pause_start {up_ack,busy,dn_req}: got %b expected 010000", {upAck, busy, dnReq});
                end
            end
            if (n == 11) begin
                compareCount++;
                if (dnReq !== 4'b1000) begin
                    mismatchCount++;
                    $display("[TB] FAIL reversal first_pause dn_req: got %b expected 1000", dnReq);
                end
            end
            if (n == 18) begin
                compareCount++;
                if (upAck !== 1'b0) begin
                    mismatchCount++;
                    $display("[TB] FAIL reversal early_ack up_ack: got %b expected 0", upAck);
                end
            end
            if (n == 19) begin
                compareCount++;
                if ({upAck, busy, dnReq} !== 6'b1_0_1111) begin
                    mismatchCount++;
                    $display("[TB] FAIL reversal pause_done {up_ack,busy,dn_req}: got %b expected 101111", {upAck, busy, dnReq});
                end
            end
        end
    endtask

    // Target 2 never acks: the resume parks at index 2 with busy high, and a
    // mid-cycle reset drops everything straight back to paused.
    task automatic test_stall_reset();
        en        = 4'b1111;
        stallMask = 4'b0100;
        upReq     = 1'b0;
        for (int n = 0; n <= 25; n++) begin
            tick();
            compareCount++;
            if (busy !== 1'b1) begin
                mismatchCount++;
                $display("[TB] FAIL stall busy edge %0d: got %b expected 1", n, busy);
            end
        end
        compareCount++;
        if ({upAck, dnReq} !== 5'b1_1000) begin
            mismatchCount++;
            $display("[TB] FAIL stall parked {up_ack,dn_req}: got %b expected 11000", {upAck, dnReq});
        end
        #3;
        reset = 1'b1;
        #1;
        compareCount++;
        if ({upAck, busy, dnReq} !== 6'b1_0_1111) begin
            mismatchCount++;
            $display("[TB] FAIL stall_reset {up_ack,busy,dn_req}: got %b expected 101111", {upAck, busy, dnReq});
        end
        upReq     = 1'b1;
        stallMask = 4'b0000;
        #3;
        reset = 1'b0;
        tick();
        compareCount++;
        if ({upAck, busy, dnReq} !== 6'b1_0_1111) begin
            mismatchCount++;
            $display("[TB] FAIL stall_reset_release {up_ack,busy,dn_req}: got %b expected 101111", {upAck, busy, dnReq});
        end
    endtask

    // Scenario sequence; each task leaves the DUT settled for the next one.
    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        test_reset();
        test_resume_all();
        test_pause_all();
        tick();
        tick();
        test_skip();
        tick();
        tick();
        test_reversal();
        tick();
        tick();
        test_stall_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
